// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential unsigned divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Step-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 trial-subtract step: shift in a dividend bit, keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;

  // The extra guard bit makes the sign of the trial difference explicit.
  always_comb begin
    trial = {rem, dividend_bit} - {2'b00, divisor};
    q_bit = ~trial[WIDTH+1];
    if (q_bit) begin
      rem_next = trial[WIDTH:0];
    end else begin
      rem_next = {rem[WIDTH-1:0], dividend_bit};
    end
  end

endmodule

// File: rtl/nonrestoring_divider_unsigned.sv
// Sequential radix-2 unsigned divider, one quotient bit per cycle.
// Optional DIVIDER_STICKY_EN builds the remainder OR-reduction onto sticky_o.
module nonrestoring_divider_unsigned
  import div_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o,
  output logic             sticky_o
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift_q;   // dividend bits drain from the top, quotient bits fill the bottom
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic             ready_q;
  logic             valid_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
  logic             sticky_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_bit (shift_q[WIDTH-1]),
    .divisor      (divisor_q),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      cnt         <= {CW{1'b0}};
      shift_q     <= {WIDTH{1'b0}};
      divisor_q   <= {WIDTH{1'b0}};
      rem         <= {(WIDTH+1){1'b0}};
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (valid_i && ready_q) begin
            shift_q   <= dividend_i;
            divisor_q <= divisor_i;
            rem       <= {(WIDTH+1){1'b0}};
            ready_q   <= 1'b0;
            if (divisor_i == {WIDTH{1'b0}}) begin
              state       <= DONE;
              valid_q     <= 1'b1;
              quotient_q  <= {WIDTH{1'b1}};
              remainder_q <= dividend_i;
              dbz_q       <= 1'b1;
`ifdef DIVIDER_STICKY_EN
              sticky_q    <= |dividend_i;
`else
              sticky_q    <= 1'b0;
`endif
            end else begin
              cnt   <= CW'(WIDTH - 1);
              state <= CALC;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        CALC: begin
          rem     <= rem_next;
          shift_q <= {shift_q[WIDTH-2:0], q_bit};
          if (cnt == {CW{1'b0}}) begin
            state       <= DONE;
            valid_q     <= 1'b1;
            quotient_q  <= {shift_q[WIDTH-2:0], q_bit};
            remainder_q <= rem_next[WIDTH-1:0];
            dbz_q       <= 1'b0;
`ifdef DIVIDER_STICKY_EN
            sticky_q    <= |rem_next[WIDTH-1:0];
`else
            sticky_q    <= 1'b0;
`endif
          end else begin
            cnt <= cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o       = ready_q;
  assign valid_o       = valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;
  assign sticky_o      = sticky_q;

endmodule

// File: tb/tb_nonrestoring_divider_unsigned.sv
// Directed and random self-checking bench for nonrestoring_divider_unsigned (WIDTH = 24).
module tb_nonrestoring_divider_unsigned;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [23:0] dividend_i = 24'd0;
  logic [23:0] divisor_i = 24'd0;
  logic        valid_o;
  logic [23:0] quotient_o;
  logic [23:0] remainder_o;
  logic        div_by_zero_o;
  logic        sticky_o;

  int checks = 0;
  int errors = 0;

  nonrestoring_divider_unsigned #(.WIDTH(24)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .valid_o       (valid_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o),
    .sticky_o      (sticky_o)
  );

  always #5 clk = ~clk;

  function automatic logic exp_sticky(input logic [23:0] rem);
`ifdef DIVIDER_STICKY_EN
    return (rem != 24'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Issue one operation; lat is the cycle (1 = first after acceptance) in which valid_o is seen.
  task automatic run_op(input logic [23:0] a, input logic [23:0] b,
                        output logic [23:0] q, output logic [23:0] r,
                        output logic dz, output logic st,
                        output int lat, output bit busy_ok);
    int guard = 0;
    while (!ready_o && guard < 60) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    valid_i = 1'b1; dividend_i = a; divisor_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!valid_o && lat < 40) begin
      if (ready_o) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (ready_o) busy_ok = 1'b0;
    q = quotient_o; r = remainder_o; dz = div_by_zero_o; st = sticky_o;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || quotient_o !== 24'd0 || remainder_o !== 24'd0 ||
        div_by_zero_o !== 1'b0 || sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%h r=%h dz=%b st=%b required rdy=1 others 0",
               ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, sticky_o);
    end
    @(negedge clk); rstn_i = 1'b1;
  endtask

  task automatic test_basic();
    logic [23:0] q, r; logic dz, st; int lat; bit busy_ok;
    run_op(24'd100, 24'd7, q, r, dz, st, lat, busy_ok);
    checks++;
    if (q !== 24'd14 || r !== 24'd2 || dz !== 1'b0) begin
      errors++; $display("FAIL basic_100_7: q=%0d r=%0d dz=%b required q=14 r=2 dz=0", q, r, dz);
    end
    checks++;
    if (lat != 25) begin
      errors++; $display("FAIL basic_latency: got %0d required 25", lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL basic_ready_low: ready_o high during op, required low");
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL basic_after_pulse: vld=%b rdy=%b required vld=0 rdy=1", valid_o, ready_o);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (quotient_o !== 24'd14 || remainder_o !== 24'd2) begin
      errors++; $display("FAIL basic_hold: q=%0d r=%0d required q=14 r=2", quotient_o, remainder_o);
    end
  endtask

  task automatic test_extremes();
    logic [23:0] a_t [3] = '{24'hFFFFFF, 24'd5, 24'h800000};
    logic [23:0] b_t [3] = '{24'd1, 24'd9, 24'h800000};
    logic [23:0] q_t [3] = '{24'hFFFFFF, 24'd0, 24'd1};
    logic [23:0] r_t [3] = '{24'd0, 24'd5, 24'd0};
    logic [23:0] q, r; logic dz, st; int lat; bit busy_ok;
    for (int i = 0; i < 3; i++) begin
      run_op(a_t[i], b_t[i], q, r, dz, st, lat, busy_ok);
      checks++;
      if (q !== q_t[i] || r !== r_t[i] || dz !== 1'b0 || lat != 25) begin
        errors++;
        $display("FAIL extreme_%0d: q=%h r=%h dz=%b lat=%0d required q=%h r=%h dz=0 lat=25",
                 i, q, r, dz, lat, q_t[i], r_t[i]);
      end
    end
  endtask

  task automatic test_div_by_zero();
    logic [23:0] q, r; logic dz, st; int lat; bit busy_ok;
    run_op(24'h123456, 24'd0, q, r, dz, st, lat, busy_ok);
    checks++;
    if (q !== 24'hFFFFFF || r !== 24'h123456 || dz !== 1'b1 || st !== exp_sticky(24'h123456)) begin
      errors++;
      $display("FAIL div_by_zero: q=%h r=%h dz=%b st=%b required q=ffffff r=123456 dz=1 st=%b",
               q, r, dz, st, exp_sticky(24'h123456));
    end
    checks++;
    if (lat != 1 || !busy_ok) begin
      errors++; $display("FAIL dbz_latency: got %0d ready_ok=%b required 1 and 1", lat, busy_ok);
    end
  endtask

  task automatic test_busy_reject();
    int pulses = 0;
    logic [23:0] q = 24'd0, r = 24'd0;
    while (!ready_o) begin @(posedge clk); #1; end
    @(negedge clk); valid_i = 1'b1; dividend_i = 24'd100; divisor_i = 24'd7;
    @(posedge clk); #1; valid_i = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 3) begin valid_i = 1'b1; dividend_i = 24'd50; divisor_i = 24'd5; end
      if (c == 15) valid_i = 1'b0;
      if (valid_o) begin pulses++; q = quotient_o; r = remainder_o; end
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != 1 || q !== 24'd14 || r !== 24'd2) begin
      errors++; $display("FAIL busy_reject: pulses=%0d q=%0d r=%0d required 1 pulse q=14 r=2", pulses, q, r);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    logic [23:0] q, r; logic dz, st; int lat; bit busy_ok;
    while (!ready_o) begin @(posedge clk); #1; end
    @(negedge clk); valid_i = 1'b1; dividend_i = 24'd100; divisor_i = 24'd7;
    @(posedge clk); #1; valid_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rstn_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || quotient_o !== 24'd0 || remainder_o !== 24'd0 ||
        div_by_zero_o !== 1'b0 || sticky_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: rdy=%b vld=%b q=%h r=%h dz=%b st=%b required rdy=1 others 0",
               ready_o, valid_o, quotient_o, remainder_o, div_by_zero_o, sticky_o);
    end
    @(negedge clk); rstn_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid_o) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_mid_no_valid: pulses=%0d required 0", pulses);
    end
    run_op(24'd81, 24'd9, q, r, dz, st, lat, busy_ok);
    checks++;
    if (q !== 24'd9 || r !== 24'd0 || lat != 25) begin
      errors++; $display("FAIL reset_mid_81_9: q=%0d r=%0d lat=%0d required q=9 r=0 lat=25", q, r, lat);
    end
  endtask

  task automatic test_sticky();
    logic [23:0] q, r; logic dz, st; int lat; bit busy_ok;
    run_op(24'd100, 24'd7, q, r, dz, st, lat, busy_ok);
    checks++;
    if (st !== exp_sticky(24'd2)) begin
      errors++; $display("FAIL sticky_100_7: got %b required %b", st, exp_sticky(24'd2));
    end
    run_op(24'd99, 24'd9, q, r, dz, st, lat, busy_ok);
    checks++;
    if (st !== 1'b0 || q !== 24'd11 || r !== 24'd0) begin
      errors++; $display("FAIL sticky_99_9: st=%b q=%0d r=%0d required st=0 q=11 r=0", st, q, r);
    end
  endtask

  task automatic test_random();
    logic [23:0] a, b, eq, er, q, r; logic dz, st; int lat; bit busy_ok;
    for (int i = 0; i < 1000; i++) begin
      a = 24'($urandom);
      b = 24'($urandom >> $urandom_range(0, 31));
      if (b == 24'd0) b = 24'd3;
      eq = a / b;
      er = a % b;
      run_op(a, b, q, r, dz, st, lat, busy_ok);
      checks++;
      if (q !== eq || r !== er || dz !== 1'b0 || st !== exp_sticky(er) || lat != 25) begin
        errors++;
        $display("FAIL random_%0d %h/%h: q=%h r=%h dz=%b st=%b lat=%0d required q=%h r=%h dz=0 st=%b lat=25",
                 i, a, b, q, r, dz, st, lat, eq, er, exp_sticky(er));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_by_zero();
    test_busy_reject();
    test_reset_mid();
    test_sticky();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
